ov7670_sccb_config: RTL and testbench
=====================================

Name: ov7670_sccb_config

Overview:
Write-only SCCB master that programs the OV7670 register set after power-up, before the camera pixel path is trusted.
- Walks an external synchronous register table of {reg_addr, value} words.
- Issues one 3-phase SCCB write per entry and honours embedded delay and end markers.
- Raises done when the sensor is configured; the top level gates VGA output on done.

Parameters:
CLK_HZ, 25_000_000, frequency of clk in Hz
SCCB_HZ, 100_000, SIOC bit rate in Hz
DEV_ADDR, 8'h42, OV7670 8-bit write ID
POWERUP_CYCLES, 25_000_000, wait between start and first transaction (1 s)
DELAY_CYCLES, 250_000, wait inserted by a delay marker (10 ms)

Ports:
clk  in  1  system clock (same 25 MHz domain as cam_xclk)
reset_n  in  1  asynchronous, active-low reset
start  in  1  single-cycle pulse; begins a configuration run
rom_addr  out  8  table index
rom_data  in  16  {reg[15:8], val[7:0]}, valid 1 cycle after rom_addr
sioc  out  1  SCCB clock, push-pull, idle high
siod_drive_low  out  1  1 = pull SIOD low; 0 = release (top level ties SIOD to 'z, pulled up)
busy  out  1  run in progress
done  out  1  sticky; table finished
write_count  out  8  number of SCCB writes issued in the current run

Behaviour:
- Reset values: sioc=1, siod_drive_low=0, busy=0, done=0, rom_addr=0, write_count=0, FSM=IDLE. Reset is asynchronous and may occur mid-transaction; the bus is released immediately, with no stop condition generated.
- QUARTER = CLK_HZ/(4*SCCB_HZ), integer division, must be ≥1. A quarter-tick counter runs only during bus states.
- IDLE:
  - start clears done and write_count, sets rom_addr=0 and busy=1, then goes to PWR_WAIT.
  - start while busy=1 is ignored.
- PWR_WAIT: count POWERUP_CYCLES, then go to FETCH.
- FETCH (2 cycles: address, then data capture):
  - rom_data==16'hFFFF → FINISH.
  - rom_data==16'hFFF0 → DELAY.
  - Otherwise latch the 27-bit shift frame {DEV_ADDR,X, reg,X, val,X}, where each X is a released 9th bit, then go to START.
- START (2 quarters): q0 sioc=1 with SIOD driven low; q1 sioc=0.
- BITS (27 bits × 4 quarters, MSB first):
  - q0: sioc=0 and set SIOD; drive_low = ~bit for data bits, 0 for X bits.
  - q1: sioc=0. q2: sioc=1. q3: sioc=1.
  - SIOD changes only in q0 while sioc is low.
  - The X bit is not sampled: SCCB ACK is don't-care, with no retry and no error.
- STOP (3 quarters): q0 sioc=0 with drive_low=1; q1 sioc=1; q2 release SIOD.
- GAP (4 quarters idle, bus released): write_count += 1 (saturating at 255), then advance.
- DELAY: count DELAY_CYCLES with the bus idle; no write_count change; then advance.
- Advance:
  - rom_addr==255 → FINISH, with no wrap.
  - Otherwise rom_addr += 1, then FETCH.
- FINISH: busy=0, done=1 (held until the next start or reset), rom_addr holds its last value, return to IDLE.
- Bus timing: one write = 2+108+3+4 = 117 quarters. start accepted in IDLE → first SIOD fall = POWERUP_CYCLES + 2 FETCH cycles (+ at most 1 cycle for the state change).
- Invariant: sioc=1 and siod_drive_low=0 in every non-bus state.

Test Plan:
1. CLK_HZ=400, SCCB_HZ=100 (QUARTER=1), POWERUP_CYCLES=10; table {0x1280, 0xFFFF}; start → one write. A bus-model decode yields bytes 0x42, 0x12, 0x80 with SIOD released on each 9th bit. Exactly 117 bus cycles, write_count=1, done=1, busy=0.
2. Same setup; table {0x1280, 0xFFF0, 0x1100, 0xFFFF}, DELAY_CYCLES=50 → ≥50 idle cycles with sioc=1 between write 1 stop and write 2 start. write_count=2 and the second frame decodes 0x42, 0x11, 0x00.
3. Protocol checker over scenario 2: SIOD edges occur only while sioc=0, except the start fall and stop rise with sioc=1. Zero violations.
4. Assert reset_n=0 during bit 10 of a write → sioc=1, siod_drive_low=0, busy=0 in the same cycle (asynchronous). A later start reruns from rom_addr=0.
5. start pulsed again mid-run → ignored, with no restart and write_count continuing. After done=1, a new start clears done and write_count to 0.
6. 256-entry table with no end marker → 256 writes; rom_addr stops at 255, write_count=255 (saturated), done=1.

Source files
------------

// File: rtl/ov7670_sccb_config.sv
`default_nettype none
// ============================================================================
//  Module      : ov7670_sccb_config
//  Description : Write-only SCCB master that walks an external synchronous
//                register table of {reg_addr, value} words and programs the
//                OV7670 after power-up. Handles delay (16'hFFF0) and end
//                (16'hFFFF) markers and raises a sticky done when finished.
//  Revision    : 1.0 - initial release
// ============================================================================
module ov7670_sccb_config #(
    parameter int          CLK_HZ         = 25_000_000,
    parameter int          SCCB_HZ        = 100_000,
    parameter logic [7:0]  DEV_ADDR       = 8'h42,
    parameter int          POWERUP_CYCLES = 25_000_000,
    parameter int          DELAY_CYCLES   = 250_000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    output logic [7:0]  rom_addr,
    input  logic [15:0] rom_data,
    output logic        sioc,
    output logic        siod_drive_low,
    output logic        busy,
    output logic        done,
    output logic [7:0]  write_count
);

    // One SIOC period is split into four quarters; each quarter lasts this
    // many clk cycles.
    localparam int          c_QUARTER  = CLK_HZ / (4 * SCCB_HZ);
    localparam logic [15:0] c_Q_LAST   = 16'(c_QUARTER - 1);
    localparam logic [31:0] c_PWR_LAST = 32'(POWERUP_CYCLES - 1);
    localparam logic [31:0] c_DLY_LAST = 32'(DELAY_CYCLES - 1);
    localparam logic [4:0]  c_TOP_BIT  = 5'd26;

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_PWR_WAIT = 4'd1;
    localparam logic [3:0] S_FETCH    = 4'd2;
    localparam logic [3:0] S_START    = 4'd3;
    localparam logic [3:0] S_BITS     = 4'd4;
    localparam logic [3:0] S_STOP     = 4'd5;
    localparam logic [3:0] S_GAP      = 4'd6;
    localparam logic [3:0] S_DELAY    = 4'd7;

    logic [3:0]  r_state;
    logic [31:0] r_cnt;          // power-up / delay cycle counter
    logic [15:0] r_qcnt;         // clk cycles within the current quarter
    logic [1:0]  r_q;            // quarter index within a bus phase
    logic [4:0]  r_bit;          // bits remaining in the frame (26..0)
    logic        r_fetch_phase;  // 0 = address cycle, 1 = data capture
    logic [26:0] r_frame;        // {dev,X, reg,X, val,X}, X bits held at 1
    logic        r_sioc;
    logic        r_sdl;
    logic        r_busy;
    logic        r_done;
    logic [7:0]  r_rom_addr;
    logic [7:0]  r_write_count;

    logic w_bus;
    logic w_q_end;

    assign w_bus   = (r_state == S_START) || (r_state == S_BITS) ||
                     (r_state == S_STOP)  || (r_state == S_GAP);
    assign w_q_end = w_bus && (r_qcnt == c_Q_LAST);

    assign sioc           = r_sioc;
    assign siod_drive_low = r_sdl;
    assign busy           = r_busy;
    assign done           = r_done;
    assign rom_addr       = r_rom_addr;
    assign write_count    = r_write_count;

    // Configuration sequencer: table walk, SCCB bit engine and registered bus outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_qcnt        <= '0;
            r_q           <= '0;
            r_bit         <= '0;
            r_fetch_phase <= 1'b0;
            r_frame       <= '0;
            r_sioc        <= 1'b1;
            r_sdl         <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_rom_addr    <= '0;
            r_write_count <= '0;
        end else begin
            // Quarter timer only runs while the bus is owned.
            if (w_bus && !w_q_end) begin
                r_qcnt <= r_qcnt + 16'd1;
            end else begin
                r_qcnt <= '0;
            end

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_done        <= 1'b0;
                        r_write_count <= '0;
                        r_rom_addr    <= '0;
                        r_busy        <= 1'b1;
                        r_cnt         <= '0;
                        r_state       <= S_PWR_WAIT;
                    end
                end

                S_PWR_WAIT: begin
                    if (r_cnt == c_PWR_LAST) begin
                        r_cnt         <= '0;
                        r_fetch_phase <= 1'b0;
                        r_state       <= S_FETCH;
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end

                // First cycle lets the table register the address; second
                // cycle captures its word.
                S_FETCH: begin
                    if (!r_fetch_phase) begin
                        r_fetch_phase <= 1'b1;
                    end else begin
                        r_fetch_phase <= 1'b0;
                        if (rom_data == 16'hFFFF) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_IDLE;
                        end else if (rom_data == 16'hFFF0) begin
                            r_cnt   <= '0;
                            r_state <= S_DELAY;
                        end else begin
                            r_frame <= {DEV_ADDR, 1'b1, rom_data[15:8], 1'b1,
                                        rom_data[7:0], 1'b1};
                            r_q     <= '0;
                            r_sioc  <= 1'b1;
                            r_sdl   <= 1'b1;   // start condition: SIOD falls with SIOC high
                            r_state <= S_START;
                        end
                    end
                end

                S_START: begin
                    if (w_q_end) begin
                        if (r_q == 2'd0) begin
                            r_q    <= 2'd1;
                            r_sioc <= 1'b0;
                        end else begin
                            r_q     <= 2'd0;
                            r_bit   <= c_TOP_BIT;
                            r_sioc  <= 1'b0;
                            r_sdl   <= ~r_frame[26];
                            r_state <= S_BITS;
                        end
                    end
                end

                // q0/q1 SIOC low, q2/q3 SIOC high; SIOD only moves on q0 entry.
                S_BITS: begin
                    if (w_q_end) begin
                        r_q <= r_q + 2'd1;
                        case (r_q)
                            2'd1: r_sioc <= 1'b1;
                            2'd3: begin
                                r_sioc <= 1'b0;
                                if (r_bit == 5'd0) begin
                                    r_sdl   <= 1'b1;   // hold SIOD low for stop
                                    r_state <= S_STOP;
                                end else begin
                                    r_bit   <= r_bit - 5'd1;
                                    r_frame <= {r_frame[25:0], 1'b1};
                                    r_sdl   <= ~r_frame[25];
                                end
                            end
                            default: ;
                        endcase
                    end
                end

                S_STOP: begin
                    if (w_q_end) begin
                        if (r_q == 2'd0) begin
                            r_q    <= 2'd1;
                            r_sioc <= 1'b1;
                        end else if (r_q == 2'd1) begin
                            r_q   <= 2'd2;
                            r_sdl <= 1'b0;     // stop condition: SIOD rises with SIOC high
                        end else begin
                            r_q     <= 2'd0;
                            r_state <= S_GAP;
                        end
                    end
                end

                S_GAP: begin
                    if (w_q_end) begin
                        r_q <= r_q + 2'd1;
                        if (r_q == 2'd3) begin
                            if (r_write_count != 8'hFF) begin
                                r_write_count <= r_write_count + 8'd1;
                            end
                            if (r_rom_addr == 8'hFF) begin
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                                r_state <= S_IDLE;
                            end else begin
                                r_rom_addr    <= r_rom_addr + 8'd1;
                                r_fetch_phase <= 1'b0;
                                r_state       <= S_FETCH;
                            end
                        end
                    end
                end

                S_DELAY: begin
                    if (r_cnt == c_DLY_LAST) begin
                        r_cnt <= '0;
                        if (r_rom_addr == 8'hFF) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_IDLE;
                        end else begin
                            r_rom_addr    <= r_rom_addr + 8'd1;
                            r_fetch_phase <= 1'b0;
                            r_state       <= S_FETCH;
                        end
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end

                default: begin
                    r_sioc  <= 1'b1;
                    r_sdl   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ov7670_sccb_config.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ov7670_sccb_config
//  Description : Self-checking bench for ov7670_sccb_config. A bus monitor
//                decodes SCCB frames, checks protocol rules and compares each
//                frame against a scoreboard filled when tables are loaded.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ov7670_sccb_config;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  rom_addr;
    logic [15:0] rom_data = 16'hFFFF;
    logic        sioc;
    logic        siod_drive_low;
    logic        busy;
    logic        done;
    logic [7:0]  write_count;

    ov7670_sccb_config #(
        .CLK_HZ        (400),
        .SCCB_HZ       (100),
        .DEV_ADDR      (8'h42),
        .POWERUP_CYCLES(10),
        .DELAY_CYCLES  (50)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .start         (start),
        .rom_addr      (rom_addr),
        .rom_data      (rom_data),
        .sioc          (sioc),
        .siod_drive_low(siod_drive_low),
        .busy          (busy),
        .done          (done),
        .write_count   (write_count)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous register table
    logic [15:0] rom [0:255];
    always @(posedge clk) rom_data <= rom[rom_addr];

    // Scoreboard of expected {dev, reg, val}
    logic [23:0] sb[$];

    // Bus monitor state
    logic        prev_sioc = 1'b1;
    logic        prev_sdl  = 1'b0;
    logic        in_frame  = 1'b0;
    int          bitcnt    = 0;
    logic [26:0] frame     = '0;
    int          violations = 0;
    int          nstart    = 0;
    int          t_stop    = 0;
    int          start_times[$];

    always @(negedge clk) begin
        logic [23:0] exp_w;
        logic [23:0] got_w;
        logic [2:0]  acks;
        if (!reset_n) begin
            in_frame = 1'b0;
            bitcnt   = 0;
        end else begin
            if ((siod_drive_low !== prev_sdl) && sioc) begin
                if (siod_drive_low && !in_frame) begin
                    in_frame = 1'b1;
                    bitcnt   = 0;
                    frame    = '0;
                    nstart++;
                    start_times.push_back(cyc);
                end else if (!siod_drive_low && in_frame && bitcnt == 27) begin
                    in_frame = 1'b0;
                    t_stop   = cyc;
                    got_w = {frame[26:19], frame[17:10], frame[8:1]};
                    acks  = {frame[18], frame[9], frame[0]};
                    n_cmp++;
                    if (sb.size() == 0) begin
                        n_fail++;
                        $display("FAIL frame_unexpected: got %h, scoreboard empty", got_w);
                    end else begin
                        exp_w = sb.pop_front();
                        if (got_w !== exp_w) begin
                            n_fail++;
                            $display("FAIL frame_bytes: got %h expected %h", got_w, exp_w);
                        end
                    end
                    n_cmp++;
                    if (acks !== 3'b111) begin
                        n_fail++;
                        $display("FAIL ack_release: got %b expected 111", acks);
                    end
                end else begin
                    violations++;
                end
            end
            if (in_frame && sioc && !prev_sioc && bitcnt < 27) begin
                frame = {frame[25:0], ~siod_drive_low};
                bitcnt++;
            end
            if (!in_frame && !sioc) violations++;
        end
        prev_sioc = sioc;
        prev_sdl  = siod_drive_low;
    end

    task automatic load_table(input logic [15:0] words[$]);
        for (int i = 0; i < 256; i++) rom[i] = 16'hFFFF;
        for (int i = 0; i < words.size(); i++) begin
            rom[i] = words[i];
            if (words[i] == 16'hFFFF) break;
            if (words[i] != 16'hFFF0) sb.push_back({8'h42, words[i]});
        end
    endtask

    task automatic pulse_start(output int t_acc);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t_acc = cyc;
    endtask

    task automatic wait_done(input int bound, input string tag);
        int i;
        for (i = 0; i < bound; i++) begin
            @(negedge clk);
            if (done && !busy) break;
        end
        if (i == bound) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s_timeout: done not seen within %0d cycles", tag, bound);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_cmp += 6;
        if (sioc !== 1'b1)            begin n_fail++; $display("FAIL rst_sioc: got %b expected 1", sioc); end
        if (siod_drive_low !== 1'b0)  begin n_fail++; $display("FAIL rst_sdl: got %b expected 0", siod_drive_low); end
        if (busy !== 1'b0)            begin n_fail++; $display("FAIL rst_busy: got %b expected 0", busy); end
        if (done !== 1'b0)            begin n_fail++; $display("FAIL rst_done: got %b expected 0", done); end
        if (rom_addr !== 8'd0)        begin n_fail++; $display("FAIL rst_rom_addr: got %0d expected 0", rom_addr); end
        if (write_count !== 8'd0)     begin n_fail++; $display("FAIL rst_write_count: got %0d expected 0", write_count); end
    endtask

    task automatic test_single_write();
        logic [15:0] t[$];
        int t_acc, sf, busy_fall, d, i;
        t = '{16'h1280, 16'hFFFF};
        load_table(t);
        start_times.delete();
        pulse_start(t_acc);
        busy_fall = -1;
        for (i = 0; i < 400; i++) begin
            @(negedge clk);
            if (!busy) begin busy_fall = cyc; break; end
        end
        n_cmp++;
        if (start_times.size() != 1) begin
            n_fail++;
            $display("FAIL single_nstart: got %0d starts expected 1", start_times.size());
        end else begin
            sf = start_times[0];
            d  = sf - t_acc;
            n_cmp += 3;
            if (d < 12 || d > 13) begin n_fail++; $display("FAIL first_fall_latency: got %0d expected 12..13", d); end
            if (t_stop - sf !== 112) begin n_fail++; $display("FAIL start_to_stop: got %0d expected 112", t_stop - sf); end
            if (busy_fall - sf !== 119) begin n_fail++; $display("FAIL bus_plus_fetch: got %0d expected 119", busy_fall - sf); end
        end
        n_cmp += 4;
        if (write_count !== 8'd1) begin n_fail++; $display("FAIL single_write_count: got %0d expected 1", write_count); end
        if (done !== 1'b1)        begin n_fail++; $display("FAIL single_done: got %b expected 1", done); end
        if (busy !== 1'b0)        begin n_fail++; $display("FAIL single_busy: got %b expected 0", busy); end
        if (sb.size() != 0)       begin n_fail++; $display("FAIL single_sb_left: got %0d expected 0", sb.size()); end
    endtask

    task automatic test_delay_and_protocol();
        logic [15:0] t[$];
        int t_acc, t_stop1, gap;
        t = '{16'h1280, 16'hFFF0, 16'h1100, 16'hFFFF};
        load_table(t);
        violations = 0;
        start_times.delete();
        pulse_start(t_acc);
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (start_times.size() == 1 && !in_frame && t_stop > start_times[0]) break;
        end
        t_stop1 = t_stop;
        wait_done(600, "delay");
        n_cmp++;
        if (start_times.size() != 2) begin
            n_fail++;
            $display("FAIL delay_nstart: got %0d expected 2", start_times.size());
        end else begin
            gap = start_times[1] - t_stop1;
            n_cmp++;
            if (gap < 50) begin n_fail++; $display("FAIL delay_gap: got %0d expected >=50", gap); end
        end
        n_cmp += 3;
        if (write_count !== 8'd2) begin n_fail++; $display("FAIL delay_write_count: got %0d expected 2", write_count); end
        if (violations != 0)      begin n_fail++; $display("FAIL protocol_violations: got %0d expected 0", violations); end
        if (sb.size() != 0)       begin n_fail++; $display("FAIL delay_sb_left: got %0d expected 0", sb.size()); end
    endtask

    task automatic test_reset_mid_write();
        logic [15:0] t[$];
        int t_acc, i;
        t = '{16'h1280, 16'hFFFF};
        load_table(t);
        pulse_start(t_acc);
        for (i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_frame && bitcnt == 10) break;
        end
        n_cmp++;
        if (i == 200) begin n_fail++; $display("FAIL reset_mid_wait: bit 10 not reached"); end
        #2 reset_n = 1'b0;
        #1;
        n_cmp += 3;
        if (sioc !== 1'b1)           begin n_fail++; $display("FAIL async_sioc: got %b expected 1", sioc); end
        if (siod_drive_low !== 1'b0) begin n_fail++; $display("FAIL async_sdl: got %b expected 0", siod_drive_low); end
        if (busy !== 1'b0)           begin n_fail++; $display("FAIL async_busy: got %b expected 0", busy); end
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        load_table(t);
        pulse_start(t_acc);
        n_cmp++;
        if (rom_addr !== 8'd0) begin n_fail++; $display("FAIL rerun_rom_addr: got %0d expected 0", rom_addr); end
        wait_done(400, "rerun");
        n_cmp += 2;
        if (write_count !== 8'd1) begin n_fail++; $display("FAIL rerun_write_count: got %0d expected 1", write_count); end
        if (sb.size() != 0)       begin n_fail++; $display("FAIL rerun_sb_left: got %0d expected 0", sb.size()); end
    endtask

    task automatic test_start_ignored();
        logic [15:0] t[$];
        int t_acc, t2, n0, i;
        t = '{16'h1280, 16'h1100, 16'h1380, 16'hFFFF};
        load_table(t);
        n0 = nstart;
        pulse_start(t_acc);
        n_cmp += 2;
        if (done !== 1'b0)        begin n_fail++; $display("FAIL restart_done_clear: got %b expected 0", done); end
        if (write_count !== 8'd0) begin n_fail++; $display("FAIL restart_wc_clear: got %0d expected 0", write_count); end
        for (i = 0; i < 300; i++) begin
            @(negedge clk);
            if (write_count == 8'd1) break;
        end
        pulse_start(t2);
        wait_done(800, "ignored");
        n_cmp += 4;
        if (write_count !== 8'd3)  begin n_fail++; $display("FAIL ignored_write_count: got %0d expected 3", write_count); end
        if (nstart - n0 != 3)      begin n_fail++; $display("FAIL ignored_frames: got %0d expected 3", nstart - n0); end
        if (rom_addr !== 8'd3)     begin n_fail++; $display("FAIL ignored_rom_addr: got %0d expected 3", rom_addr); end
        if (sb.size() != 0)        begin n_fail++; $display("FAIL ignored_sb_left: got %0d expected 0", sb.size()); end
    endtask

    task automatic test_full_table();
        logic [15:0] t[$];
        logic [7:0]  r;
        int t_acc, iv;
        for (int i = 0; i < 256; i++) begin
            r = 8'(i);
            t.push_back({r, ~r});
        end
        load_table(t);
        start_times.delete();
        pulse_start(t_acc);
        wait_done(256 * 119 + 1000, "full");
        n_cmp++;
        if (start_times.size() != 256) begin
            n_fail++;
            $display("FAIL full_nstart: got %0d expected 256", start_times.size());
        end else begin
            iv = start_times[1] - start_times[0];
            n_cmp++;
            if (iv != 119) begin n_fail++; $display("FAIL write_interval: got %0d expected 119", iv); end
        end
        n_cmp += 4;
        if (write_count !== 8'd255) begin n_fail++; $display("FAIL full_write_count: got %0d expected 255", write_count); end
        if (rom_addr !== 8'd255)    begin n_fail++; $display("FAIL full_rom_addr: got %0d expected 255", rom_addr); end
        if (done !== 1'b1)          begin n_fail++; $display("FAIL full_done: got %b expected 1", done); end
        if (sb.size() != 0)         begin n_fail++; $display("FAIL full_sb_left: got %0d expected 0", sb.size()); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 16'hFFFF;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        test_reset();
        test_single_write();
        test_delay_and_protocol();
        test_reset_mid_write();
        test_start_ignored();
        test_full_table();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
